// File: rtl/module_serial_adder.sv
// rtl/module_serial_adder.sv - bit-serial adder driving a single full-adder cell
// One sum bit per clock, LSB first, carry held in c_r between steps.

module module_full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_carry,
   output logic o_sum,
   output logic o_carry
);
   assign o_sum   = i_a ^ i_b ^ i_carry;
   assign o_carry = (i_a & i_b) | (i_carry & (i_a ^ i_b));
endmodule

module module_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_carry,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_next;
   logic [CW-1:0]    cnt;
   logic             c_r;
   logic             fa_sum, fa_carry;
   logic             accept, last_step;

   module_full_adder u_fa (
      .i_a     (a_sr[0]),
      .i_b     (b_sr[0]),
      .i_carry (c_r),
      .o_sum   (fa_sum),
      .o_carry (fa_carry)
   );

   // New bits enter at the MSB so the word is in LSB order after WIDTH steps.
   generate
      if (WIDTH == 1) begin : g_w1
         assign sum_next = fa_sum;
      end else begin : g_wn
         assign sum_next = {fa_sum, sum_sr[WIDTH-1:1]};
      end
   endgenerate

   assign accept    = ((state_q == IDLE) || (state_q == DONE)) && i_start;
   assign last_step = (state_q == RUN) && (cnt == LAST);
   assign o_busy    = (state_q == RUN);
   assign o_done    = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_start) state_d = RUN;
         RUN:     if (cnt == LAST) state_d = DONE;
         DONE:    state_d = i_start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         a_sr    <= '0;
         b_sr    <= '0;
         sum_sr  <= '0;
         cnt     <= '0;
         c_r     <= 1'b0;
         o_sum   <= '0;
         o_carry <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_sr <= i_a;
            b_sr <= i_b;
            c_r  <= i_carry;
            cnt  <= '0;
         end else if (state_q == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= sum_next;
            c_r    <= fa_carry;
            cnt    <= cnt + 1'b1;
         end
         if (last_step) begin
            o_sum   <= sum_next;
            o_carry <= fa_carry;
         end
      end
   end
endmodule

// File: tb/tb_module_serial_adder.sv
// tb/tb_module_serial_adder.sv - directed checks of module_serial_adder at WIDTH 8, 1 and 16

module tb_module_serial_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       start8 = 0, c8 = 0, busy8, done8, co8;
   logic [7:0] a8 = 0, b8 = 0, sum8;
   logic       start1 = 0, c1 = 0, busy1, done1, co1;
   logic [0:0] a1 = 0, b1 = 0, sum1;
   logic        start16 = 0, c16 = 0, busy16, done16, co16;
   logic [15:0] a16 = 0, b16 = 0, sum16;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   module_serial_adder #(.WIDTH(8)) dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_a(a8), .i_b(b8), .i_carry(c8),
      .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_carry(co8));

   module_serial_adder #(.WIDTH(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_a(a1), .i_b(b1), .i_carry(c1),
      .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_carry(co1));

   module_serial_adder #(.WIDTH(16)) dut16 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start16), .i_a(a16), .i_b(b16), .i_carry(c16),
      .o_busy(busy16), .o_done(done16), .o_sum(sum16), .o_carry(co16));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and return #1 after the accepting edge.
   task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
      start8 = 1'b1; a8 = a; b8 = b; c8 = c;
      tick();
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
   endtask

   // Edges counted including the accepting edge; bounded at 40.
   task automatic wait8(output int n);
      n = 1;
      while (!done8 && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      int pulses;
      logic [16:0] exp17;

      tick();
      tick();
      check("rst_busy8", busy8, 0);
      check("rst_done8", done8, 0);
      check("rst_sum8", sum8, 0);
      check("rst_carry8", co8, 0);
      check("rst_busy1", busy1, 0);
      check("rst_sum16", sum16, 0);
      rst_n = 1'b1;
      tick();
      check("idle_done8", done8, 0);

      go8(8'h5A, 8'h3C, 1'b0);
      check("run_busy8", busy8, 1);
      wait8(n);
      check("lat_5a3c", n, 9);
      check("sum_5a3c", sum8, 8'h96);
      check("co_5a3c", co8, 0);
      check("done_busy8", busy8, 0);
      tick();
      check("done_one_cycle", done8, 0);

      go8(8'hFF, 8'h01, 1'b0);
      wait8(n);
      check("sum_ff01", sum8, 8'h00);
      check("co_ff01", co8, 1);
      tick();

      go8(8'hFF, 8'hFF, 1'b1);
      wait8(n);
      check("sum_ffff1", sum8, 8'hFF);
      check("co_ffff1", co8, 1);
      tick();

      // A request during RUN must be dropped.
      go8(8'h10, 8'h20, 1'b0);
      tick();
      tick();
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
      tick();
      start8 = 1'b0;
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         if (done8) begin
            pulses++;
            check("sum_ignore", sum8, 8'h30);
            check("co_ignore", co8, 0);
         end
         tick();
      end
      check("pulses_ignore", pulses, 1);
      check("idle_after_ignore", busy8, 0);

      // Back-to-back: second request issued in the DONE cycle.
      go8(8'h01, 8'h01, 1'b0);
      wait8(n);
      check("sum_b2b_1", sum8, 8'h02);
      check("co_b2b_1", co8, 0);
      check("busy_b2b_gap", busy8, 0);
      go8(8'h80, 8'h80, 1'b0);
      check("busy_b2b_rerun", busy8, 1);
      check("sum_b2b_hold", sum8, 8'h02);
      wait8(n);
      check("lat_b2b", n, 9);
      check("sum_b2b_2", sum8, 8'h00);
      check("co_b2b_2", co8, 1);
      tick();

      // Reset asserted so that edge 4 after acceptance samples it.
      go8(8'h7F, 8'h01, 1'b0);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      check("rst_mid_busy", busy8, 0);
      check("rst_mid_done", done8, 0);
      check("rst_mid_sum", sum8, 0);
      check("rst_mid_carry", co8, 0);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8) pulses++;
         tick();
      end
      check("rst_mid_no_done", pulses, 0);
      go8(8'h03, 8'h04, 1'b0);
      wait8(n);
      check("sum_after_rst", sum8, 8'h07);
      check("co_after_rst", co8, 0);
      tick();

      // WIDTH=1: RUN lasts a single cycle.
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      tick();
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      check("w1_busy", busy1, 1);
      check("w1_not_done", done1, 0);
      tick();
      check("w1_done", done1, 1);
      check("w1_sum", sum1, 1);
      check("w1_carry", co1, 1);
      tick();
      check("w1_done_drop", done1, 0);

      // WIDTH=16 random operands against a plain integer sum.
      for (int k = 0; k < 200; k++) begin
         start16 = 1'b1;
         a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
         exp17 = {1'b0, a16} + {1'b0, b16} + {16'd0, c16};
         tick();
         start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
         n = 1;
         while (!done16 && n < 40) begin
            tick();
            n++;
         end
         check("w16_lat", n, 17);
         check("w16_res", {co16, sum16}, exp17);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
